hwloop_ctrl: RTL and testbench
==============================

# hwloop_ctrl

Zero-overhead hardware-loop controller for the KIRA RISC-V fetch stage. Holds up to two loop descriptors (start, end, iteration count). It watches the current fetch PC and drives the `pcsel == 2` redirect request and `pc_hwloop` target consumed by the next-PC generator. It is the producer side of the next-PC hardware-loop interface: the next-PC stage selects `pc_hwloop` whenever this block raises `hwloop_jump`.

## Interface
- `CNT_W`, 32: iteration counter width.
- `NUM_LVL`, derived (2 with `KIRA_HWLOOP_NEST_EN`, else 1): number of loop levels. Level 0 is innermost.
- `clk`  in  1  clock.
- `rst`  in  1  reset, synchronous, active-high.
- `pc`  in  32  current fetch PC.
- `ena`  in  1  fetch advance; state updates only when high.
- `br_taken`  in  1  branch/jump redirect this cycle; suppresses loop evaluation.
- `cfg_valid`  in  1  configuration request.
- `cfg_ready`  out  1  configuration can be accepted.
- `cfg_level`  in  1  target level (ignored when `NUM_LVL` = 1).
- `cfg_start`  in  32  loop body first instruction address.
- `cfg_end`  in  32  loop body last instruction address.
- `cfg_count`  in  CNT_W  iteration count.
- `cfg_err`  out  1  registered one-cycle pulse: request rejected.
- `hwloop_jump`  out  1  combinational redirect request; maps to `pcsel = 2`.
- `pc_hwloop`  out  32  redirect target; 0 when `hwloop_jump` = 0.
- `loop_active`  out  NUM_LVL  per-level ACTIVE flag.
- `loop_done`  out  NUM_LVL  registered one-cycle pulse: level finished its last iteration.

## Operation
- **Per-level FSM.** States are IDLE and ACTIVE. Each level keeps registers `start`, `end` and `cnt`.
- **Configuration accept.** A request is accepted when `cfg_valid && cfg_ready`.
  - `cfg_ready` = 1 when the target level is IDLE and `rst` = 0.
  - Rejected configurations: `cfg_count` = 0, `cfg_start[1:0]` ≠ 0, `cfg_end[1:0]` ≠ 0, or `cfg_start` > `cfg_end`. A rejected configuration pulses `cfg_err` and leaves the level IDLE.
  - A valid configuration loads the registers and moves the level to ACTIVE.
- **Evaluation.** Evaluation is enabled only when `ena` = 1 and `br_taken` = 0. An ACTIVE level "hits" when `pc == end`.
- **Hit with `cnt` > 1.**
  - `hwloop_jump` = 1 and `pc_hwloop` = `start`.
  - `cnt` decrements on the clock edge.
- **Hit with `cnt` == 1 (final pass).**
  - No jump; the fetch falls through to `pc + 4`.
  - `cnt` becomes 0, the level returns to IDLE, and `loop_done` pulses.
- **Priority.**
  - Level 0 is evaluated first.
  - If level 0 jumps, level 1 is not evaluated and is not modified.
  - If level 0 finishes on the same `end` address as level 1, level 1 is evaluated in the same cycle and may jump.
- **Simultaneous configuration and hit on the same level.** This cannot occur, because a configuration is accepted only for an IDLE level.
- **Configuration and hit on different levels in the same cycle.** Both take effect.
- **`br_taken` = 1 or `ena` = 0.** `hwloop_jump` = 0 and no counter changes. A configuration may still be accepted.

## Timing
- **Reset values.** All levels IDLE. `start`, `end` and `cnt` = 0. `hwloop_jump` = 0, `pc_hwloop` = 0, `loop_active` = 0, `loop_done` = 0, `cfg_err` = 0.
- **Ready.** `cfg_ready` = 0 while `rst` = 1.
- **Configuration latency.** A configuration accepted at edge N sets `loop_active` from cycle N+1. The first possible hit is in cycle N+1.
- **Jump latency.** `hwloop_jump` and `pc_hwloop` are combinational from `pc` and the registered state, with zero cycles of latency. They are valid in the same cycle that `pc` equals `end`.
- **Pulse timing.** `loop_done` and `cfg_err` are asserted in the cycle after the triggering edge, for exactly one cycle.
- **Reset mid-loop.** Asserting `rst` during an active loop clears all state at the next edge; no further jumps occur.
- **Single-instruction loop.** With `start == end`, the block issues a back-to-back jump every `ena` cycle until `cnt` reaches 1.
- **Counter range.** The counter never wraps: 0 is unreachable while ACTIVE.

## Configuration
- **Macro:** `KIRA_HWLOOP_NEST_EN`.
- **Defined:** two levels, with the level-0/level-1 priority rules above; `cfg_level` is honoured.
- **Undefined:** one level only. `cfg_level` is ignored, and `loop_active` and `loop_done` are 1 bit wide.

## Test plan
- **Basic 3-iteration loop.** Configure start=0x100, end=0x10C, count=3, then sequential PCs. Required: jumps to 0x100 at the 1st and 2nd visits of 0x10C; fall-through at the 3rd; `loop_done` pulses one cycle later; `loop_active` → 0.
- **Invalid configuration rejection.** Configure count=0, then start=0x104/end=0x100, then end=0x10E. Required: each pulses `cfg_err`; level stays IDLE; no jump ever.
- **Redirect suppression.** Hold `ena` = 0 at pc=0x10C, then `br_taken` = 1 at pc=0x10C. Required: `hwloop_jump` = 0 and `cnt` unchanged in both cycles; the next `ena`-qualified visit jumps.
- **Nested loops (`KIRA_HWLOOP_NEST_EN`).** L0 = 0x200–0x208 ×2 and L1 = 0x1F0–0x20C ×2. Required: L0 body executes 4 times in total, L1 jumps once to 0x1F0, and L0 is re-armed by software between outer passes.
- **Shared end address.** L0 and L1 both end at 0x300, L0 count=1, L1 count=2. Required: at pc=0x300, L0 finishes and L1 jumps to its start in the same cycle.
- **Reset mid-loop.** Assert `rst` with `cnt` = 5 active. Required: all outputs return to reset values the next cycle; pc=end produces no jump.

Source files
------------

// File: rtl/hwloop_ctrl_if.sv
// Hardware-loop controller bus: fetch PC/redirect side plus the loop configuration channel.
// Level count follows KIRA_HWLOOP_NEST_EN (2 levels when defined, 1 otherwise).
interface hwloop_ctrl_if #(
  parameter int CNT_W = 32
);
`ifdef KIRA_HWLOOP_NEST_EN
  localparam int NUM_LVL = 2;
`else
  localparam int NUM_LVL = 1;
`endif

  logic [31:0]        pc;
  logic               ena;
  logic               br_taken;
  logic               cfg_valid;
  logic               cfg_ready;
  logic               cfg_level;
  logic [31:0]        cfg_start;
  logic [31:0]        cfg_end;
  logic [CNT_W-1:0]   cfg_count;
  logic               cfg_err;
  logic               hwloop_jump;
  logic [31:0]        pc_hwloop;
  logic [NUM_LVL-1:0] loop_active;
  logic [NUM_LVL-1:0] loop_done;

  modport master (
    output pc, ena, br_taken, cfg_valid, cfg_level, cfg_start, cfg_end, cfg_count,
    input  cfg_ready, cfg_err, hwloop_jump, pc_hwloop, loop_active, loop_done
  );

  modport slave (
    input  pc, ena, br_taken, cfg_valid, cfg_level, cfg_start, cfg_end, cfg_count,
    output cfg_ready, cfg_err, hwloop_jump, pc_hwloop, loop_active, loop_done
  );
endinterface

// File: rtl/hwloop_ctrl.sv
// Zero-overhead loop controller: redirect is combinational from pc, done/err pulse one cycle later.
// Config is accepted only while the target level is IDLE; KIRA_HWLOOP_NEST_EN adds a second level.
module hwloop_ctrl #(
  parameter int CNT_W = 32
) (
  input logic          clk,
  input logic          rst,
  hwloop_ctrl_if.slave bus
);
`ifdef KIRA_HWLOOP_NEST_EN
  localparam int NUM_LVL = 2;
`else
  localparam int NUM_LVL = 1;
`endif

  typedef enum logic {IDLE, ACTIVE} state_t;

  state_t             state   [NUM_LVL];
  logic [31:0]        start_q [NUM_LVL];
  logic [31:0]        end_q   [NUM_LVL];
  logic [CNT_W-1:0]   cnt_q   [NUM_LVL];
  logic [NUM_LVL-1:0] done_q;
  logic               err_q;

  logic [NUM_LVL-1:0] idle_vec;
  logic [NUM_LVL-1:0] active_vec;
  logic [NUM_LVL-1:0] cfg_sel;
  logic [NUM_LVL-1:0] jump;
  logic [NUM_LVL-1:0] fin;
  logic [31:0]        target;
  logic               eval_en;
  logic               cfg_bad;
  logic               cfg_acc;
  logic               cfg_ready;

`ifdef KIRA_HWLOOP_NEST_EN
  assign cfg_sel = bus.cfg_level ? 2'b10 : 2'b01;
`else
  logic unused_cfg_level;
  assign unused_cfg_level = bus.cfg_level;
  assign cfg_sel          = 1'b1;
`endif

  always_comb begin
    for (int l = 0; l < NUM_LVL; l++) begin
      idle_vec[l]   = (state[l] == IDLE);
      active_vec[l] = (state[l] == ACTIVE);
    end
  end

  assign cfg_ready = !rst && ((cfg_sel & idle_vec) != '0);
  assign cfg_acc   = bus.cfg_valid && cfg_ready;
  assign cfg_bad   = (bus.cfg_count == '0) || (bus.cfg_start[1:0] != 2'b00) ||
                     (bus.cfg_end[1:0] != 2'b00) || (bus.cfg_start > bus.cfg_end);
  assign eval_en   = bus.ena && !bus.br_taken && !rst;

  // Lower levels win: once a level jumps, outer levels are neither evaluated nor touched.
  always_comb begin
    logic blocked;
    logic hit;
    blocked = 1'b0;
    jump    = '0;
    fin     = '0;
    target  = '0;
    for (int l = 0; l < NUM_LVL; l++) begin
      hit     = eval_en && !blocked && active_vec[l] && (bus.pc == end_q[l]);
      jump[l] = hit && (cnt_q[l] > CNT_W'(1));
      fin[l]  = hit && !jump[l];
      if (jump[l]) target = start_q[l];
      blocked = blocked || jump[l];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int l = 0; l < NUM_LVL; l++) begin
        state[l]   <= IDLE;
        start_q[l] <= '0;
        end_q[l]   <= '0;
        cnt_q[l]   <= '0;
      end
      done_q <= '0;
      err_q  <= 1'b0;
    end else begin
      err_q  <= cfg_acc && cfg_bad;
      done_q <= fin;
      for (int l = 0; l < NUM_LVL; l++) begin
        case (state[l])
          IDLE: begin
            if (cfg_acc && cfg_sel[l] && !cfg_bad) begin
              start_q[l] <= bus.cfg_start;
              end_q[l]   <= bus.cfg_end;
              cnt_q[l]   <= bus.cfg_count;
              state[l]   <= ACTIVE;
            end
          end
          ACTIVE: begin
            if (jump[l]) begin
              cnt_q[l] <= cnt_q[l] - CNT_W'(1);
            end else if (fin[l]) begin
              cnt_q[l] <= '0;
              state[l] <= IDLE;
            end
          end
        endcase
      end
    end
  end

  assign bus.cfg_ready   = cfg_ready;
  assign bus.cfg_err     = err_q;
  assign bus.hwloop_jump = |jump;
  assign bus.pc_hwloop   = target;
  assign bus.loop_active = active_vec;
  assign bus.loop_done   = done_q;
endmodule

// File: tb/tb_hwloop_ctrl.sv
// Bench for hwloop_ctrl: directed loop scenarios plus a random fetch/config walk,
// checked every cycle against a descriptor-level model of the loop rules.
module tb_hwloop_ctrl;
`ifdef KIRA_HWLOOP_NEST_EN
  localparam int NUM_LVL = 2;
`else
  localparam int NUM_LVL = 1;
`endif

  logic clk;
  logic rst;
  hwloop_ctrl_if #(.CNT_W(32)) bus();

  hwloop_ctrl #(.CNT_W(32)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int errors = 0;
  int checks = 0;
  bit chk_en = 1'b0;

  // Loop descriptors as the program sees them.
  bit   [1:0]  m_act  = '0;
  logic [31:0] m_s[2] = '{32'h0, 32'h0};
  logic [31:0] m_e[2] = '{32'h0, 32'h0};
  logic [31:0] m_c[2] = '{32'h0, 32'h0};
  bit   [1:0]  m_done = '0;
  bit          m_err  = 1'b0;

  int          n_jump, n_done, n_body;
  logic [31:0] last_tgt;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic bit cfg_bad(input logic [31:0] s, input logic [31:0] e, input logic [31:0] c);
    return (c == 0) || (s % 4 != 0) || (e % 4 != 0) || (s > e);
  endfunction

  function automatic int cur_lvl();
`ifdef KIRA_HWLOOP_NEST_EN
    return int'(bus.cfg_level);
`else
    return 0;
`endif
  endfunction

  // Walk the levels innermost-first; the first one that loops back wins.
  function automatic void model_eval(output bit jmp, output logic [31:0] tgt,
                                     output int jl, output bit [1:0] fin);
    jmp = 1'b0; tgt = 32'h0; jl = -1; fin = '0;
    if (rst || !bus.ena || bus.br_taken) return;
    for (int l = 0; l < NUM_LVL; l++) begin
      if (m_act[l] && bus.pc == m_e[l]) begin
        if (m_c[l] > 1) begin
          jmp = 1'b1; tgt = m_s[l]; jl = l;
          return;
        end
        fin[l] = 1'b1;
      end
    end
  endfunction

  bit          u_j;
  logic [31:0] u_t;
  int          u_jl, u_lv;
  bit   [1:0]  u_f;
  bit          u_acc;

  always @(posedge clk) begin
    if (rst) begin
      m_act = '0; m_done = '0; m_err = 1'b0;
      for (int l = 0; l < 2; l++) begin m_s[l] = 0; m_e[l] = 0; m_c[l] = 0; end
    end else begin
      model_eval(u_j, u_t, u_jl, u_f);
      u_lv   = cur_lvl();
      u_acc  = bus.cfg_valid && !m_act[u_lv];
      m_err  = u_acc && cfg_bad(bus.cfg_start, bus.cfg_end, bus.cfg_count);
      m_done = u_f;
      if (u_jl >= 0) m_c[u_jl] = m_c[u_jl] - 1;
      for (int l = 0; l < 2; l++) if (u_f[l]) begin m_act[l] = 1'b0; m_c[l] = 0; end
      if (u_acc && !m_err) begin
        m_act[u_lv] = 1'b1;
        m_s[u_lv] = bus.cfg_start; m_e[u_lv] = bus.cfg_end; m_c[u_lv] = bus.cfg_count;
      end
    end
  end

  bit          c_j;
  logic [31:0] c_t;
  int          c_jl;
  bit   [1:0]  c_f;

  always @(negedge clk) begin
    if (chk_en) begin
      model_eval(c_j, c_t, c_jl, c_f);
      chk("hwloop_jump", bus.hwloop_jump, c_j);
      chk("pc_hwloop", bus.pc_hwloop, c_t);
      chk("cfg_ready", bus.cfg_ready, !rst && !m_act[cur_lvl()]);
      chk("loop_active", bus.loop_active, m_act[NUM_LVL-1:0]);
      chk("loop_done", bus.loop_done, m_done[NUM_LVL-1:0]);
      chk("cfg_err", bus.cfg_err, m_err);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clr_cnt();
    n_jump = 0; n_done = 0; n_body = 0; last_tgt = 32'h0;
  endtask

  task automatic do_cfg(input bit lvl, input logic [31:0] s, input logic [31:0] e, input logic [31:0] c);
    bus.ena = 1'b0; bus.br_taken = 1'b0;
    bus.cfg_valid = 1'b1; bus.cfg_level = lvl;
    bus.cfg_start = s; bus.cfg_end = e; bus.cfg_count = c;
    tick();
    bus.cfg_valid = 1'b0;
  endtask

  // Acts as the next-PC stage: follows the model's redirect, otherwise pc + 4.
  task automatic run(input logic [31:0] pc0, input int n);
    logic [31:0] cur;
    bit          j;
    logic [31:0] t;
    int          jl;
    bit   [1:0]  f;
    cur = pc0;
    for (int i = 0; i < n; i++) begin
      bus.pc = cur; bus.ena = 1'b1; bus.br_taken = 1'b0;
      @(negedge clk);
      if (bus.pc == 32'h200) n_body++;
      if (bus.hwloop_jump) begin n_jump++; last_tgt = bus.pc_hwloop; end
      if (bus.loop_done != '0) n_done++;
      model_eval(j, t, jl, f);
      tick();
      cur = j ? t : cur + 32'd4;
    end
    bus.ena = 1'b0;
  endtask

  initial begin
    logic [31:0] cur, nxt, s, e, c;
    bit          j;
    logic [31:0] t;
    int          jl, k;
    bit   [1:0]  f;

    rst = 1'b1;
    bus.pc = 32'h0; bus.ena = 1'b0; bus.br_taken = 1'b0;
    bus.cfg_valid = 1'b0; bus.cfg_level = 1'b0;
    bus.cfg_start = 32'h0; bus.cfg_end = 32'h0; bus.cfg_count = 32'h0;
    tick();
    chk_en = 1'b1;
    @(negedge clk);
    chk("rst_cfg_ready", bus.cfg_ready, 1'b0);
    chk("rst_loop_active", bus.loop_active, '0);
    chk("rst_hwloop_jump", bus.hwloop_jump, 1'b0);
    tick();
    rst = 1'b0;

    // Basic 3-iteration loop
    do_cfg(1'b0, 32'h100, 32'h10C, 32'd3);
    clr_cnt();
    run(32'h100, 14);
    chk("basic_jumps", n_jump, 2);
    chk("basic_target", last_tgt, 32'h100);
    chk("basic_done", n_done, 1);
    chk("basic_active_end", bus.loop_active, '0);

    // Invalid configurations
    do_cfg(1'b0, 32'h100, 32'h10C, 32'd0);
    @(negedge clk); chk("err_count0", bus.cfg_err, 1'b1);
    do_cfg(1'b0, 32'h104, 32'h100, 32'd2);
    @(negedge clk); chk("err_order", bus.cfg_err, 1'b1);
    do_cfg(1'b0, 32'h100, 32'h10E, 32'd2);
    @(negedge clk); chk("err_align", bus.cfg_err, 1'b1);
    chk("err_idle", bus.loop_active, '0);
    clr_cnt();
    run(32'h100, 6);
    chk("err_no_jump", n_jump, 0);

    // Redirect suppression
    do_cfg(1'b0, 32'h100, 32'h10C, 32'd3);
    bus.pc = 32'h10C; bus.ena = 1'b0;
    @(negedge clk); chk("sup_ena0", bus.hwloop_jump, 1'b0);
    tick();
    bus.ena = 1'b1; bus.br_taken = 1'b1;
    @(negedge clk); chk("sup_br", bus.hwloop_jump, 1'b0);
    tick();
    clr_cnt();
    run(32'h10C, 1);
    chk("sup_jump_after", n_jump, 1);
    chk("sup_target", last_tgt, 32'h100);
    clr_cnt();
    run(32'h100, 10);
    chk("sup_jumps_left", n_jump, 1);
    chk("sup_done", n_done, 1);

    // Reset mid-loop
    do_cfg(1'b0, 32'h400, 32'h40C, 32'd5);
    rst = 1'b1; bus.pc = 32'h40C; bus.ena = 1'b1;
    tick();
    rst = 1'b0;
    @(negedge clk);
    chk("rst_mid_jump", bus.hwloop_jump, 1'b0);
    chk("rst_mid_active", bus.loop_active, '0);
    tick();
    bus.ena = 1'b0;

`ifdef KIRA_HWLOOP_NEST_EN
    // Nested loops, L0 re-armed between outer passes
    do_cfg(1'b1, 32'h1F0, 32'h20C, 32'd2);
    do_cfg(1'b0, 32'h200, 32'h208, 32'd2);
    clr_cnt();
    run(32'h1F0, 14);
    chk("nest_pass1_jumps", n_jump, 2);
    chk("nest_outer_target", last_tgt, 32'h1F0);
    do_cfg(1'b0, 32'h200, 32'h208, 32'd2);
    n_jump = 0;
    run(32'h1FC, 10);
    chk("nest_body_count", n_body, 4);
    chk("nest_pass2_jumps", n_jump, 1);
    chk("nest_all_idle", bus.loop_active, 2'b00);

    // Shared end address
    do_cfg(1'b1, 32'h2F0, 32'h300, 32'd2);
    do_cfg(1'b0, 32'h2F8, 32'h300, 32'd1);
    bus.ena = 1'b1; bus.pc = 32'h300;
    @(negedge clk);
    chk("shared_jump", bus.hwloop_jump, 1'b1);
    chk("shared_target", bus.pc_hwloop, 32'h2F0);
    tick();
    bus.pc = 32'h2F0;
    @(negedge clk);
    chk("shared_done", bus.loop_done, 2'b01);
    chk("shared_active", bus.loop_active, 2'b10);
    tick();
    bus.ena = 1'b0;
    clr_cnt();
    run(32'h2F4, 6);
    chk("shared_l1_done", n_done, 1);
`endif

    // Random fetch walk with interleaved configs, branches, stalls and resets
    cur = 32'h100;
    for (int i = 0; i < 3000; i++) begin
      k = $urandom_range(0, 7);
      s = 32'h100 + 32'd4 * $urandom_range(0, 7);
      e = s + 32'd4 * $urandom_range(0, 3);
      c = $urandom_range(0, 3);
      if (k == 0) c = 0;
      if (k == 1) s = s + 2;
      if (k == 2) e = e + 1;
      if (k == 3) s = e + 4;
      bus.cfg_valid = ($urandom_range(0, 99) < 12);
      bus.cfg_level = 1'($urandom_range(0, 1));
      bus.cfg_start = s; bus.cfg_end = e; bus.cfg_count = c;
      bus.ena = ($urandom_range(0, 3) != 0);
      bus.br_taken = ($urandom_range(0, 7) == 0);
      rst = ($urandom_range(0, 299) == 0);
      bus.pc = cur;
      @(negedge clk);
      model_eval(j, t, jl, f);
      if (j) nxt = t;
      else if (bus.br_taken) nxt = 32'h100 + 32'd4 * $urandom_range(0, 7);
      else if (bus.ena) nxt = cur + 32'd4;
      else nxt = cur;
      if (nxt > 32'h11C) nxt = 32'h100 + 32'd4 * $urandom_range(0, 3);
      tick();
      cur = nxt;
    end
    bus.cfg_valid = 1'b0; rst = 1'b0;
    tick();

    chk_en = 1'b0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
